fmul_normalize_round: RTL

Parametrised normalize-and-round stage for the floating-point multiplier datapath, placed between the mantissa multiplier and the final pack/exception stage. It takes the raw double-width mantissa product with its pre-biased exponent, normalises by at most one bit, rounds in one of five IEEE-754 modes, and passes the sign and exception flags through unchanged. A two-stage pipeline with a valid/busy stall handshake replaces the fixed 25-bit, single-cycle, round-to-nearest-even-only stage.

---
 rtl/fmul_normalize_round.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/fmul_normalize_round.sv
// fmul_normalize_round
//
// Normalize-and-round stage of the floating-point multiplier datapath. It sits
// between the mantissa multiplier and the pack/exception stage. The raw
// 2*FRACT_W-bit mantissa product is normalised by at most one bit. It is then
// rounded in one of five IEEE-754 modes. Sign and exception flags pass
// through unchanged. No saturation or overflow detection is done here.
//
// Pipeline: stage 1 holds the normalised mantissa, guard, sticky, exponent,
// sign, mode and flags. Stage 2 holds the rounded result. The latency is two
// cycles and the throughput is one beat per cycle. A valid/busy handshake lets
// an empty stage refill while the stage after it is stalled.
//
// Parameters
//   FRACT_W  mantissa width including the hidden bit (minimum 4)
//   EXP_W    exponent width; exponent arithmetic wraps modulo 2^EXP_W
//
// Ports
//   iCLOCK         clock, rising edge
//   inRESET        asynchronous reset, active low
//   iRESET_SYNC    synchronous clear, active high, highest priority
//   iDATA_VALID    input beat present
//   oDATA_BUSY     block cannot accept a beat this cycle
//   iDATA_SIGN     product sign
//   iDATA_EXP      exponent before normalisation
//   iDATA_FRACT    raw mantissa product (2*FRACT_W bits)
//   iROUND_MODE    0 RNE, 1 RTZ, 2 RUP, 3 RDN, 4 RMM, 5-7 behave as RNE
//   iDATA_EXCEPT   exception flags {A0,B0,A1,B1,FRACT_A0,FRACT_B0}
//   oDATA_VALID    output beat present
//   iDATA_BUSY     downstream stall
//   oDATA_SIGN / oDATA_EXP / oDATA_FRACT / oDATA_EXCEPT   rounded result
//   oDATA_INEXACT  result was rounded
//
// Configuration macro: FMUL_NR_INEXACT_EN
//   defined   : the inexact bit is carried through the pipeline and
//               oDATA_INEXACT is qualified with oDATA_VALID
//   undefined : no inexact register is built and oDATA_INEXACT is tied to 0

module fmul_normalize_round #(
    parameter int FRACT_W = 25,
    parameter int EXP_W   = 13
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iRESET_SYNC,
    input  logic                 iDATA_VALID,
    output logic                 oDATA_BUSY,
    input  logic                 iDATA_SIGN,
    input  logic [EXP_W-1:0]     iDATA_EXP,
    input  logic [2*FRACT_W-1:0] iDATA_FRACT,
    input  logic [2:0]           iROUND_MODE,
    input  logic [5:0]           iDATA_EXCEPT,
    output logic                 oDATA_VALID,
    input  logic                 iDATA_BUSY,
    output logic                 oDATA_SIGN,
    output logic [EXP_W-1:0]     oDATA_EXP,
    output logic [FRACT_W-1:0]   oDATA_FRACT,
    output logic [5:0]           oDATA_EXCEPT,
    output logic                 oDATA_INEXACT
);

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RUP = 3'd2,
        RM_RDN = 3'd3,
        RM_RMM = 3'd4
    } round_mode_t;

    // Handshake
    logic hold1, hold2, accept;
    logic v1, v2;

    // Normaliser outputs (combinational, from the input beat)
    logic [FRACT_W-1:0] norm_m;
    logic               norm_g;
    logic               norm_s;
    logic [EXP_W-1:0]   norm_e;

    // Stage 1 registers
    logic [FRACT_W-1:0] s1_m;
    logic               s1_g;
    logic               s1_s;
    logic [EXP_W-1:0]   s1_e;
    logic               s1_sign;
    logic [2:0]         s1_mode;
    logic [5:0]         s1_except;

    // Rounder outputs (combinational, from stage 1)
    logic               round_inc;
    logic [FRACT_W-1:0] rnd_fract;
    logic [EXP_W-1:0]   rnd_exp;

    // Stage 2 registers
    logic               s2_sign;
    logic [EXP_W-1:0]   s2_exp;
    logic [FRACT_W-1:0] s2_fract;
    logic [5:0]         s2_except;

    // A stage stalls only when it is full and the stage after it is stalled.
    // An empty stage therefore always refills.
    assign hold2      = v2 & iDATA_BUSY;
    assign hold1      = v1 & hold2;
    assign oDATA_BUSY = hold1;
    assign accept     = iDATA_VALID & ~hold1;

    // Shift by one bit when the product's top bit is set. The guard bit is the
    // bit just below the kept mantissa. The sticky bit ORs everything below it.
    always_comb begin
        norm_m = '0;
        norm_g = 1'b0;
        norm_s = 1'b0;
        norm_e = iDATA_EXP;
        if (iDATA_FRACT[2*FRACT_W-1]) begin
            norm_m = iDATA_FRACT[2*FRACT_W-1:FRACT_W];
            norm_g = iDATA_FRACT[FRACT_W-1];
            norm_s = |iDATA_FRACT[FRACT_W-2:0];
            norm_e = iDATA_EXP + EXP_W'(1);
        end else begin
            norm_m = iDATA_FRACT[2*FRACT_W-2:FRACT_W-1];
            norm_g = iDATA_FRACT[FRACT_W-2];
            norm_s = |iDATA_FRACT[FRACT_W-3:0];
        end
    end

    // Stage 1: data moves only with an accepted beat, so the register keeps
    // its last contents while the stage is empty.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            v1        <= 1'b0;
            s1_m      <= '0;
            s1_g      <= 1'b0;
            s1_s      <= 1'b0;
            s1_e      <= '0;
            s1_sign   <= 1'b0;
            s1_mode   <= '0;
            s1_except <= '0;
        end else if (iRESET_SYNC) begin
            v1        <= 1'b0;
            s1_m      <= '0;
            s1_g      <= 1'b0;
            s1_s      <= 1'b0;
            s1_e      <= '0;
            s1_sign   <= 1'b0;
            s1_mode   <= '0;
            s1_except <= '0;
        end else if (!hold1) begin
            v1 <= accept;
            if (accept) begin
                s1_m      <= norm_m;
                s1_g      <= norm_g;
                s1_s      <= norm_s;
                s1_e      <= norm_e;
                s1_sign   <= iDATA_SIGN;
                s1_mode   <= iROUND_MODE;
                s1_except <= iDATA_EXCEPT;
            end
        end
    end

    // Rounding uses the mode captured with the beat. Unused mode codes
    // behave as round-to-nearest-even.
    always_comb begin
        round_inc = 1'b0;
        case (s1_mode)
            RM_RTZ:  round_inc = 1'b0;
            RM_RUP:  round_inc = (s1_g | s1_s) & ~s1_sign;
            RM_RDN:  round_inc = (s1_g | s1_s) & s1_sign;
            RM_RMM:  round_inc = s1_g;
            default: round_inc = s1_g & (s1_m[0] | s1_s);
        endcase
    end

    // Carry out of an all-ones mantissa renormalises to 1.000...0 and bumps
    // the exponent. This avoids a wider adder.
    always_comb begin
        rnd_fract = s1_m + FRACT_W'(round_inc);
        rnd_exp   = s1_e;
        if (round_inc && (&s1_m)) begin
            rnd_fract = {1'b1, {(FRACT_W-1){1'b0}}};
            rnd_exp   = s1_e + EXP_W'(1);
        end
    end

    // Stage 2: the result holds steady whenever downstream stalls a valid beat.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            v2        <= 1'b0;
            s2_sign   <= 1'b0;
            s2_exp    <= '0;
            s2_fract  <= '0;
            s2_except <= '0;
        end else if (iRESET_SYNC) begin
            v2        <= 1'b0;
            s2_sign   <= 1'b0;
            s2_exp    <= '0;
            s2_fract  <= '0;
            s2_except <= '0;
        end else if (!hold2) begin
            v2 <= v1;
            if (v1) begin
                s2_sign   <= s1_sign;
                s2_exp    <= rnd_exp;
                s2_fract  <= rnd_fract;
                s2_except <= s1_except;
            end
        end
    end

`ifdef FMUL_NR_INEXACT_EN
    logic s2_inexact;

    // The inexact flag follows the beat. It loads under the same conditions
    // as the rest of stage 2.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            s2_inexact <= 1'b0;
        end else if (iRESET_SYNC) begin
            s2_inexact <= 1'b0;
        end else if (!hold2 && v1) begin
            s2_inexact <= s1_g | s1_s;
        end
    end

    assign oDATA_INEXACT = v2 & s2_inexact;
`else
    assign oDATA_INEXACT = 1'b0;
`endif

    assign oDATA_VALID  = v2;
    assign oDATA_SIGN   = s2_sign;
    assign oDATA_EXP    = s2_exp;
    assign oDATA_FRACT  = s2_fract;
    assign oDATA_EXCEPT = s2_except;

endmodule
